snake_game_ctrl: RTL

Game-sequencing controller for the snake VGA design. It sits between the debounced push-buttons (start, l, r, u, d, h) and the snake body/render datapath. It owns the game state machine, the movement tick, the head position and direction, and the length and BCD score that feed the seven-segment drivers. Collision with the snake body and food detection are computed by the datapath from this block's next-head outputs.

---
 rtl/snake_game_ctrl_if.sv | 44 ++++
 rtl/snake_game_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl_if.sv
// snake_game_ctrl_if: buttons and datapath feedback into the controller,
// game status and head/score outputs back to the datapath and display.
//
// Signalling: there is no valid/ready pair here. Buttons are debounced levels
// and a press is their rising edge. food_hit/self_hit are levels that must
// describe (nxt_x, nxt_y) on the terminal-count edge. move_tick and grow are
// single-cycle pulses, and the head/dir/length/score values in that same cycle
// are already the updated ones.
interface snake_game_ctrl_if;
    logic       start;
    logic       l;
    logic       r;
    logic       u;
    logic       d;
    logic       h;
    logic       food_hit;
    logic       self_hit;
    logic [1:0] state;
    logic [1:0] dir;
    logic [5:0] nxt_x;
    logic [4:0] nxt_y;
    logic [5:0] head_x;
    logic [4:0] head_y;
    logic       move_tick;
    logic       grow;
    logic [4:0] length;
    logic [3:0] score_ones;
    logic [3:0] score_tens;
    logic       game_over;

    // Board/bench side: drives buttons and hit flags, observes game status.
    modport master (
        output start, l, r, u, d, h, food_hit, self_hit,
        input  state, dir, nxt_x, nxt_y, head_x, head_y, move_tick, grow,
        input  length, score_ones, score_tens, game_over
    );

    // Controller side.
    modport slave (
        input  start, l, r, u, d, h, food_hit, self_hit,
        output state, dir, nxt_x, nxt_y, head_x, head_y, move_tick, grow,
        output length, score_ones, score_tens, game_over
    );
endinterface

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game state machine, movement tick, head position and
// direction, snake length and two-digit BCD score.
module snake_game_ctrl #(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int TICK_DIV = 5_000_000,
    parameter int MAX_LEN  = 16
) (
    input  logic             clk,
    input  logic             rst,
    snake_game_ctrl_if.slave bus
);
    localparam int               CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [5:0]       X_INIT    = 6'(GRID_W / 2);
    localparam logic [4:0]       Y_INIT    = 5'(GRID_H / 2);
    localparam logic [5:0]       X_MAX     = 6'(GRID_W - 1);
    localparam logic [4:0]       Y_MAX     = 5'(GRID_H - 1);
    localparam logic [4:0]       LEN_INIT  = 5'd3;
    localparam logic [4:0]       LEN_MAX   = 5'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // Opposite directions differ only in bit 0.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    state_t           state_q, state_d;
    dir_t             dir_q, dir_d;
    dir_t             pend_q, pend_d;
    logic [5:0]       head_x_q, head_x_d;
    logic [4:0]       head_y_q, head_y_d;
    logic [4:0]       len_q, len_d;
    logic [3:0]       ones_q, ones_d;
    logic [3:0]       tens_q, tens_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic             move_tick_q, move_tick_d;
    logic             grow_q, grow_d;

    // Button order: start, h, u, d, l, r.
    logic [5:0]       btn_q;
    logic [5:0]       btn_now;
    logic [5:0]       press;
    logic             press_start;
    logic             press_h;

    dir_t             dir_req;
    logic             dir_req_vld;
    logic [5:0]       nxt_x;
    logic [4:0]       nxt_y;
    logic             wall;

    function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

    assign btn_now     = {bus.start, bus.h, bus.u, bus.d, bus.l, bus.r};
    assign press       = btn_now & ~btn_q;
    assign press_start = press[5];
    assign press_h     = press[4];

    // Resolve simultaneous direction presses: up beats down beats left beats right.
    always_comb begin
        dir_req     = DIR_RIGHT;
        dir_req_vld = 1'b1;
        if (press[3])      dir_req = DIR_UP;
        else if (press[2]) dir_req = DIR_DOWN;
        else if (press[1]) dir_req = DIR_LEFT;
        else if (press[0]) dir_req = DIR_RIGHT;
        else               dir_req_vld = 1'b0;
    end

    // Next head for the pending direction; stays on the head when it would leave the grid.
    always_comb begin
        wall  = 1'b0;
        nxt_x = head_x_q;
        nxt_y = head_y_q;
        case (pend_q)
            DIR_UP: begin
                if (head_y_q == 5'd0) wall = 1'b1;
                else                  nxt_y = head_y_q - 5'd1;
            end
            DIR_DOWN: begin
                if (head_y_q >= Y_MAX) wall = 1'b1;
                else                   nxt_y = head_y_q + 5'd1;
            end
            DIR_LEFT: begin
                if (head_x_q == 6'd0) wall = 1'b1;
                else                  nxt_x = head_x_q - 6'd1;
            end
            default: begin
                if (head_x_q >= X_MAX) wall = 1'b1;
                else                   nxt_x = head_x_q + 6'd1;
            end
        endcase
    end

    // Game FSM next state plus all datapath register updates.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        pend_d      = pend_q;
        head_x_d    = head_x_q;
        head_y_d    = head_y_q;
        len_d       = len_q;
        ones_d      = ones_q;
        tens_d      = tens_q;
        tick_d      = tick_q;
        move_tick_d = 1'b0;
        grow_d      = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (press_start) begin
                    state_d  = ST_RUN;
                    dir_d    = DIR_RIGHT;
                    pend_d   = DIR_RIGHT;
                    head_x_d = X_INIT;
                    head_y_d = Y_INIT;
                    len_d    = LEN_INIT;
                    ones_d   = 4'd0;
                    tens_d   = 4'd0;
                    tick_d   = '0;
                end
            end
            ST_RUN: begin
                if (press_h) begin
                    // Pausing edge is not a counted run cycle, so the tick count is held.
                    state_d = ST_PAUSE;
                end else begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (wall || bus.self_hit) begin
                            state_d = ST_OVER;
                        end else begin
                            head_x_d    = nxt_x;
                            head_y_d    = nxt_y;
                            dir_d       = pend_q;
                            move_tick_d = 1'b1;
                            if (bus.food_hit) begin
                                grow_d = 1'b1;
                                if (len_q < LEN_MAX) len_d = len_q + 5'd1;
                                if (!(tens_q == 4'd9 && ones_q == 4'd9)) begin
                                    if (ones_q == 4'd9) begin
                                        ones_d = 4'd0;
                                        tens_d = tens_q + 4'd1;
                                    end else begin
                                        ones_d = ones_q + 4'd1;
                                    end
                                end
                            end
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                    // Compare against the direction committed after this edge so a
                    // press on the move edge cannot reverse the snake into itself.
                    if (dir_req_vld && !is_opposite(dir_req, dir_d)) pend_d = dir_req;
                end
            end
            ST_PAUSE: begin
                if (press_h) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_RIGHT;
            pend_q      <= DIR_RIGHT;
            head_x_q    <= X_INIT;
            head_y_q    <= Y_INIT;
            len_q       <= LEN_INIT;
            ones_q      <= 4'd0;
            tens_q      <= 4'd0;
            tick_q      <= '0;
            move_tick_q <= 1'b0;
            grow_q      <= 1'b0;
            btn_q       <= 6'd0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            head_x_q    <= head_x_d;
            head_y_q    <= head_y_d;
            len_q       <= len_d;
            ones_q      <= ones_d;
            tens_q      <= tens_d;
            tick_q      <= tick_d;
            move_tick_q <= move_tick_d;
            grow_q      <= grow_d;
            btn_q       <= btn_now;
        end
    end

    assign bus.state      = state_q;
    assign bus.dir        = dir_q;
    assign bus.nxt_x      = nxt_x;
    assign bus.nxt_y      = nxt_y;
    assign bus.head_x     = head_x_q;
    assign bus.head_y     = head_y_q;
    assign bus.move_tick  = move_tick_q;
    assign bus.grow       = grow_q;
    assign bus.length     = len_q;
    assign bus.score_ones = ones_q;
    assign bus.score_tens = tens_q;
    assign bus.game_over  = (state_q == ST_OVER);
endmodule
